// File: rtl/calc_cmd_sequencer.sv
// Command FIFO and execute-pulse sequencer feeding the 8-bit accumulator
// calculator; samples its flags after each execute and can halt on overflow.
module calc_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int GAP   = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [3:0]                 push_op,
   input  logic [7:0]                 push_operand,
   input  logic                       flush,
   input  logic                       resume,
   input  logic                       halt_on_ovf,
   input  logic [2:0]                 flags_in,
   output logic                       exec_en,
   output logic [3:0]                 exec_op,
   output logic [7:0]                 exec_operand,
   output logic [2:0]                 last_flags,
   output logic                       halted,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int GW = $clog2(GAP + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      HALT
   } state_t;

   state_t          state;
   state_t          state_d;
   logic [11:0]     mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [GW-1:0]   gap_cnt;
   logic [GW-1:0]   gap_d;
   logic            push_fire;
   logic            pop;
   logic            first_wait;

   // full queue refuses even when a pop lands on the same edge
   assign push_ready = (count < CW'(DEPTH)) && !flush;
   assign push_fire  = push_valid && push_ready;
   assign first_wait = (state == WAIT) && (gap_cnt == GW'(GAP));
   assign halted     = (state == HALT);

   always_comb begin
      state_d = state;
      gap_d   = gap_cnt;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!flush && count != '0) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            gap_d   = GW'(GAP);
         end
         WAIT: begin
            gap_d = gap_cnt - 1'b1;
            if (flush)
               state_d = IDLE;
            else if (first_wait && halt_on_ovf && flags_in[2])
               state_d = HALT;
            else if (gap_cnt == GW'(1))
               state_d = IDLE;
         end
         HALT: begin
            if (flush || resume)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         gap_cnt      <= '0;
         exec_en      <= 1'b0;
         exec_op      <= '0;
         exec_operand <= '0;
         last_flags   <= '0;
      end else begin
         state   <= state_d;
         gap_cnt <= gap_d;
         exec_en <= (state_d == ISSUE);
         if (pop)
            {exec_op, exec_operand} <= mem[rd_ptr];
         // flags from the execute edge are valid in the first WAIT cycle
         if (first_wait)
            last_flags <= flags_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_fire) begin
            mem[wr_ptr] <= {push_op, push_operand};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_fire) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: vector table, directed corner sequences and
// random traffic checked against a queue-based timing model.
module tb_calc_cmd_sequencer;

   localparam int DEPTH = 4;
   localparam int GAP   = 1;
   localparam longint INF = 64'd1 << 40;

   logic       clk;
   logic       rst_n;
   logic       push_valid;
   logic       push_ready;
   logic [3:0] push_op;
   logic [7:0] push_operand;
   logic       flush;
   logic       resume;
   logic       halt_on_ovf;
   logic [2:0] flags_in;
   logic       exec_en;
   logic [3:0] exec_op;
   logic [7:0] exec_operand;
   logic [2:0] last_flags;
   logic       halted;
   logic [2:0] count;

   calc_cmd_sequencer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .push_valid(push_valid),
      .push_ready(push_ready),
      .push_op(push_op),
      .push_operand(push_operand),
      .flush(flush),
      .resume(resume),
      .halt_on_ovf(halt_on_ovf),
      .flags_in(flags_in),
      .exec_en(exec_en),
      .exec_op(exec_op),
      .exec_operand(exec_operand),
      .last_flags(last_flags),
      .halted(halted),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: command queue plus abstract issue timing
   logic [11:0] m_q[$];
   logic        m_en;
   logic [3:0]  m_op;
   logic [7:0]  m_opd;
   logic        m_halt;
   logic [2:0]  m_flags;
   longint      cyc;
   longint      last_pulse;
   longint      idle_from;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_en       = 1'b0;
      m_op       = '0;
      m_opd      = '0;
      m_halt     = 1'b0;
      m_flags    = '0;
      last_pulse = -1000;
      idle_from  = 0;
   endtask

   task automatic idle_inputs();
      push_valid   = 1'b0;
      push_op      = '0;
      push_operand = '0;
      flush        = 1'b0;
      resume       = 1'b0;
      flags_in     = '0;
   endtask

   task automatic step(input logic pv, input logic [3:0] op,
                       input logic [7:0] opd, input logic fl,
                       input logic rs, input logic hov,
                       input logic [2:0] flg);
      int     n;
      logic   pfire;
      logic   nxt_pulse;
      logic   nxt_halt;
      logic [11:0] cmd;
      @(negedge clk);
      chk("exec_en", 32'(exec_en), 32'(m_en));
      chk("exec_op", 32'(exec_op), 32'(m_op));
      chk("exec_operand", 32'(exec_operand), 32'(m_opd));
      chk("count", 32'(count), 32'(m_q.size()));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("last_flags", 32'(last_flags), 32'(m_flags));
      push_valid   = pv;
      push_op      = op;
      push_operand = opd;
      flush        = fl;
      resume       = rs;
      halt_on_ovf  = hov;
      flags_in     = flg;
      #1;
      n = m_q.size();
      chk("push_ready", 32'(push_ready), 32'((n < DEPTH) && !fl));
      pfire     = pv && (n < DEPTH) && !fl;
      nxt_pulse = !fl && !m_halt && (n > 0) && (cyc >= idle_from);
      nxt_halt  = m_halt;
      if (cyc == last_pulse + 1) begin
         m_flags = flg;
         if (hov && flg[2] && !fl) begin
            nxt_halt  = 1'b1;
            idle_from = INF;
         end
      end
      if (m_halt && rs && !fl) begin
         nxt_halt  = 1'b0;
         idle_from = cyc + 1;
      end
      if (fl) begin
         m_q.delete();
         nxt_halt = 1'b0;
         if (!m_en && idle_from > cyc + 1)
            idle_from = cyc + 1;
      end
      if (nxt_pulse) begin
         cmd        = m_q.pop_front();
         m_op       = cmd[11:8];
         m_opd      = cmd[7:0];
         last_pulse = cyc + 1;
         idle_from  = cyc + GAP + 2;
      end
      if (pfire)
         m_q.push_back({op, opd});
      m_en   = nxt_pulse;
      m_halt = nxt_halt;
      cyc++;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   typedef struct {
      logic       pv;
      logic [3:0] op;
      logic [7:0] opd;
      logic       e_en;
      logic [2:0] e_cnt;
      logic       e_rdy;
   } vec_t;

   vec_t tbl [25];
   int   pulses;
   int   k;
   logic acc;

   initial begin
      // single push latency, then fill-to-full with no pass-through
      tbl[0]  = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd0, 1'b1};
      tbl[1]  = '{1'b1, 4'h0, 8'h05, 1'b0, 3'd0, 1'b1};
      tbl[2]  = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd1, 1'b1};
      tbl[3]  = '{1'b0, 4'h0, 8'h00, 1'b1, 3'd0, 1'b1};
      tbl[4]  = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd0, 1'b1};
      tbl[5]  = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd0, 1'b1};
      tbl[6]  = '{1'b1, 4'h0, 8'h10, 1'b0, 3'd0, 1'b1};
      tbl[7]  = '{1'b1, 4'h1, 8'h11, 1'b0, 3'd1, 1'b1};
      tbl[8]  = '{1'b1, 4'h2, 8'h12, 1'b1, 3'd1, 1'b1};
      tbl[9]  = '{1'b1, 4'h3, 8'h13, 1'b0, 3'd2, 1'b1};
      tbl[10] = '{1'b1, 4'h4, 8'h14, 1'b0, 3'd3, 1'b1};
      tbl[11] = '{1'b1, 4'h5, 8'h15, 1'b1, 3'd3, 1'b1};
      tbl[12] = '{1'b1, 4'h6, 8'h16, 1'b0, 3'd4, 1'b0};
      tbl[13] = '{1'b1, 4'h6, 8'h16, 1'b0, 3'd4, 1'b0};
      tbl[14] = '{1'b0, 4'h0, 8'h00, 1'b1, 3'd3, 1'b1};
      tbl[15] = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd3, 1'b1};
      tbl[16] = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd3, 1'b1};
      tbl[17] = '{1'b0, 4'h0, 8'h00, 1'b1, 3'd2, 1'b1};
      tbl[18] = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd2, 1'b1};
      tbl[19] = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd2, 1'b1};
      tbl[20] = '{1'b0, 4'h0, 8'h00, 1'b1, 3'd1, 1'b1};
      tbl[21] = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd1, 1'b1};
      tbl[22] = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd1, 1'b1};
      tbl[23] = '{1'b0, 4'h0, 8'h00, 1'b1, 3'd0, 1'b1};
      tbl[24] = '{1'b0, 4'h0, 8'h00, 1'b0, 3'd0, 1'b1};

      cyc = 0;
      halt_on_ovf = 1'b0;
      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      #23;
      chk("rst exec_en", 32'(exec_en), 32'd0);
      chk("rst count", 32'(count), 32'd0);
      chk("rst push_ready", 32'(push_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].pv, tbl[i].op, tbl[i].opd, 1'b0, 1'b0, 1'b0, 3'b000);
         chk($sformatf("tbl%0d exec_en", i), 32'(exec_en), 32'(tbl[i].e_en));
         chk($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d push_ready", i), 32'(push_ready),
             32'(tbl[i].e_rdy));
      end
      idle_steps(4);

      // overflow halt, then resume
      step(1'b1, 4'hA, 8'h01, 1'b0, 1'b0, 1'b1, 3'b000);
      step(1'b1, 4'hB, 8'h02, 1'b0, 1'b0, 1'b1, 3'b000);
      step(1'b1, 4'hC, 8'h03, 1'b0, 1'b0, 1'b1, 3'b000);
      chk("halt pulse op", 32'(exec_op), 32'hA);
      step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b100);
      step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000);
      chk("halt halted", 32'(halted), 32'd1);
      chk("halt last_flags", 32'(last_flags), 32'b100);
      chk("halt count", 32'(count), 32'd2);
      for (int i = 0; i < 4; i++)
         step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000);
      chk("halt still", 32'(halted), 32'd1);
      step(1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 3'b000);
      step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000);
      chk("resume halted", 32'(halted), 32'd0);
      step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000);
      chk("resume exec_en", 32'(exec_en), 32'd1);
      chk("resume exec_op", 32'(exec_op), 32'hB);
      idle_steps(10);

      // flush while a pulse is on the wire, with a push in the same cycle
      for (int i = 0; i < 4; i++)
         step(1'b1, 4'(i + 1), 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 3'b000);
      step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
      step(1'b1, 4'hF, 8'hFF, 1'b1, 1'b0, 1'b0, 3'b000);
      chk("flush exec_en", 32'(exec_en), 32'd1);
      chk("flush push_ready", 32'(push_ready), 32'd0);
      chk("flush pre count", 32'(count), 32'd2);
      step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
      chk("flush count", 32'(count), 32'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
         pulses += int'(exec_en);
      end
      chk("flush no pulses", 32'(pulses), 32'd0);

      // asynchronous reset in the middle of a pulse
      for (int i = 0; i < 4; i++)
         step(1'b1, 4'(i + 5), 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 3'b000);
      step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
      step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
      chk("prereset exec_en", 32'(exec_en), 32'd1);
      chk("prereset count", 32'(count), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("midrst exec_en", 32'(exec_en), 32'd0);
      chk("midrst count", 32'(count), 32'd0);
      chk("midrst halted", 32'(halted), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
         pulses += int'(exec_en);
      end
      chk("postrst no pulses", 32'(pulses), 32'd0);

      // pointer wrap: 2*DEPTH+1 commands through the queue
      k = 0;
      pulses = 0;
      while (k < 2 * DEPTH + 1) begin
         acc = (m_q.size() < DEPTH);
         step(1'b1, 4'(k), 8'(8'h40 + k), 1'b0, 1'b0, 1'b0, 3'b000);
         pulses += int'(exec_en);
         if (acc)
            k++;
      end
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
         pulses += int'(exec_en);
      end
      chk("wrap pulses", 32'(pulses), 32'(2 * DEPTH + 1));
      chk("wrap count", 32'(count), 32'd0);

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         step(($urandom % 3) != 0,
              4'($urandom),
              8'($urandom),
              ($urandom % 40) == 0,
              ($urandom % 6) == 0,
              ((i / 100) % 2) == 1,
              3'($urandom_range(0, 7)));
      end
      idle_steps(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/calc_cmd_sequencer.md
Name: calc_cmd_sequencer

Overview:
Command queue and issue sequencer that sits directly upstream of the 8-bit accumulator calculator. It buffers {opcode, operand} commands from a host and drives the calculator's operand bus, opcode bus and execute strobe, issuing one single-cycle execute pulse per command at a controlled rate. It samples the calculator's {overflow, neg, zero} flags after each execute and can halt the command stream on overflow.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
GAP, 1, idle cycles in WAIT after each execute pulse; minimum 1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
push_valid  in  1  host offers a command
push_ready  out  1  queue can accept; combinational: (count < DEPTH) && !flush
push_op  in  4  calculator opcode
push_operand  in  8  calculator operand
flush  in  1  synchronous clear of queue and halt
resume  in  1  leave HALT
halt_on_ovf  in  1  enable halt when sampled overflow = 1
flags_in  in  3  calculator flags {overflow, neg, zero}
exec_en  out  1  execute strobe to calculator; registered
exec_op  out  4  opcode to calculator; registered
exec_operand  out  8  operand to calculator; registered
last_flags  out  3  flags sampled after the most recent execute
halted  out  1  high while in HALT
count  out  $clog2(DEPTH+1)  queue occupancy

Behaviour:
- Reset (asynchronous, immediate): exec_en=0, exec_op=0, exec_operand=0, last_flags=0, halted=0, count=0, pointers=0, state=IDLE. push_ready=1 while flush=0. Reset mid-pulse drops exec_en at once; queued commands are lost.
- Push: accepted on the clock edge where push_valid && push_ready. Entry written at the tail.
- No pass-through: when the queue is full, push_ready=0 even in a cycle where a pop occurs.
- Simultaneous push and pop when not full: count is unchanged.
- FSM states:
  - IDLE: exec_en=0. At the edge where count>0, pop the head, register its op and operand onto exec_op/exec_operand, set exec_en=1, go to ISSUE.
  - ISSUE: lasts exactly 1 cycle with exec_en=1. At the next edge: exec_en=0, gap counter=GAP, go to WAIT.
  - WAIT: lasts exactly GAP cycles. In its first cycle, capture flags_in into last_flags. If halt_on_ovf=1 and flags_in[2]=1 at that capture, go to HALT at the end of that cycle. Otherwise return to IDLE after GAP cycles.
  - HALT: halted=1, exec_en=0. Pushes are still accepted and the queue is kept. resume=1 goes to IDLE, halted=0.
- Flag timing: the calculator registers its flags at the execute edge, so they are valid in the cycle after the exec_en cycle. That cycle is the first WAIT cycle.
- Issue rate: back-to-back execute pulses are GAP+2 cycles apart.
- Latency: a push accepted at edge N into an empty queue with FSM in IDLE gives exec_en=1 between edges N+1 and N+2.
- exec_op and exec_operand hold their values after the pulse until the next pop. Opcodes are passed through unchanged, including codes the calculator treats as unused.
- flush (synchronous, highest priority): at the next edge, count=0, pointers=0, halted=0.
  - From HALT or WAIT the FSM goes to IDLE.
  - An ISSUE pulse already on the wire completes normally; its flags are still sampled.
  - flush=1 forces push_ready=0, so a push in the same cycle is dropped.
- flush and resume in the same cycle: flush wins (its effect includes leaving HALT).
- Pointers wrap modulo DEPTH. count saturates structurally at DEPTH: it never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then push {op=0, operand=0x05} at edge 10 -> exec_en high between edges 11 and 12 with exec_op=0, exec_operand=0x05. count goes 1 then 0. push_ready stays 1.
- GAP=1, push 4 commands back-to-back (ops 0,1,2,3) -> a 5th push sees push_ready=0 after the 4th accept. Execute pulses are 3 cycles apart, in FIFO order, each exactly 1 cycle wide.
- halt_on_ovf=1, 3 commands queued; drive flags_in=3'b100 in the cycle after the 1st pulse -> last_flags=3'b100, halted=1, no further exec_en, count=2. Pulse resume -> the 2nd command issues 2 cycles later.
- flush asserted during ISSUE with 2 entries queued, plus push_valid in the same cycle -> the current pulse completes, count=0, the push is not accepted, and no further pulses occur.
- Assert rst_n=0 mid-pulse with the queue half full -> exec_en=0 immediately, count=0, halted=0. After release, no pulses until a new push.
- Wrap-around: 2*DEPTH+1 pushes interleaved with issues -> execute order matches push order and count ends at 0.
